// File: rtl/text_screen_pkg.sv
// Shared state encoding and width helpers for the text-mode screen buffer.
package text_screen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  function automatic int width_for(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/text_screen_ram.sv
// Simple dual-port cell RAM: read-only port A, read-first read/write port B with byte enables.
module text_screen_ram #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    ADDR_WIDTH    = 11,
  parameter string                 MEM_INIT_FILE = "",
  parameter logic [DATA_WIDTH-1:0] MEM_INIT_VAL  = '0,
  localparam int                   BE_WIDTH      = DATA_WIDTH / 8,
  localparam int                   DEPTH         = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  en_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  en_b,
  input  logic [BE_WIDTH-1:0]   we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Power-up contents only; the array itself is never reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = MEM_INIT_VAL;
  end

  always_ff @(posedge clk) begin
    if (en_a) dout_a <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (en_b) begin
      dout_b <= mem[addr_b];
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (we_b[b]) mem[addr_b][b*8 +: 8] <= din_b[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/text_screen_buffer.sv
// Text-mode screen buffer: scrolled renderer read pipeline, CPU port and clear/scroll fill engine.
//   state     | meaning
//   ST_IDLE   | CPU owns RAM port B, commands accepted
//   ST_CLEAR  | writing fill word to every visible cell
//   ST_SCROLL | writing fill word to the row that just scrolled out of view
module text_screen_buffer
  import text_screen_pkg::*;
#(
  parameter int                    COLUMNS       = 80,
  parameter int                    ROWS          = 25,
  parameter int                    DATA_WIDTH    = 16,
  parameter string                 MEM_INIT_FILE = "",
  parameter logic [DATA_WIDTH-1:0] MEM_INIT_VAL  = 16'h0000,
  localparam int                   COL_WIDTH     = width_for(COLUMNS),
  localparam int                   ROW_WIDTH     = width_for(ROWS),
  localparam int                   ADDR_WIDTH    = width_for(COLUMNS * ROWS),
  localparam int                   BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  renderEnable,
  input  logic [COL_WIDTH-1:0]  renderColumn,
  input  logic [ROW_WIDTH-1:0]  renderRow,
  output logic [DATA_WIDTH-1:0] renderData,
  output logic                  renderValid,
  input  logic                  cpuRequest,
  output logic                  cpuReady,
  input  logic                  cpuWrite,
  input  logic [BE_WIDTH-1:0]   cpuByteEnable,
  input  logic [ADDR_WIDTH-1:0] cpuAddress,
  input  logic [DATA_WIDTH-1:0] cpuWriteData,
  output logic [DATA_WIDTH-1:0] cpuReadData,
  output logic                  cpuReadValid,
  input  logic                  clearStart,
  input  logic                  scrollStart,
  input  logic [DATA_WIDTH-1:0] fillValue,
  output logic                  busy,
  output logic [ROW_WIDTH-1:0]  scrollRow
);

  localparam int                   CELLS    = COLUMNS * ROWS;
  localparam logic [ROW_WIDTH:0]   ROWS_EXT = ROWS[ROW_WIDTH:0];
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(ROWS - 1);

  state_t                state, state_nx;
  logic                  cmd_clear, cmd_scroll, cpu_accept;
  logic [ADDR_WIDTH-1:0] fill_addr, fill_left;
  logic [DATA_WIDTH-1:0] fill_word;
  logic [ROW_WIDTH-1:0]  scroll_row;

  logic                  ram_en_a, ram_en_b;
  logic [BE_WIDTH-1:0]   ram_we_b;
  logic [ADDR_WIDTH-1:0] ram_addr_b;
  logic [DATA_WIDTH-1:0] ram_din_b, ram_dout_a, ram_dout_b;

  logic [ROW_WIDTH:0]    phys_sum, phys_row;
  logic                  render_in_range;
  logic [ADDR_WIDTH-1:0] render_addr;
  logic                  s1_valid, s1_in_range, s2_valid, s2_in_range;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  cpu_rd_pending;

  assign cpuReady   = (state == ST_IDLE);
  assign cpu_accept = cpuRequest && cpuReady;
  assign busy       = (state != ST_IDLE);
  assign scrollRow  = scroll_row;

  always_comb begin
    state_nx   = state;
    cmd_clear  = 1'b0;
    cmd_scroll = 1'b0;
    ram_en_b   = cpu_accept;
    ram_we_b   = (cpu_accept && cpuWrite) ? cpuByteEnable : '0;
    ram_addr_b = cpuAddress;
    ram_din_b  = cpuWriteData;
    case (state)
      ST_IDLE: begin
        if (clearStart) begin
          state_nx  = ST_CLEAR;
          cmd_clear = 1'b1;
        end else if (scrollStart) begin
          state_nx   = ST_SCROLL;
          cmd_scroll = 1'b1;
        end
      end
      ST_CLEAR, ST_SCROLL: begin
        ram_en_b   = 1'b1;
        ram_we_b   = '1;
        ram_addr_b = fill_addr;
        ram_din_b  = fill_word;
        if (fill_left == '0) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // A reset edge must not land one more fill write.
    if (!resetN) begin
      ram_en_b = 1'b0;
      ram_we_b = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      scroll_row <= '0;
      fill_addr  <= '0;
      fill_left  <= '0;
      fill_word  <= '0;
    end else begin
      state <= state_nx;
      if (cmd_clear) begin
        fill_addr <= '0;
        fill_left <= ADDR_WIDTH'(CELLS - 1);
        fill_word <= fillValue;
      end else if (cmd_scroll) begin
        fill_addr  <= ADDR_WIDTH'(scroll_row) * ADDR_WIDTH'(COLUMNS);
        fill_left  <= ADDR_WIDTH'(COLUMNS - 1);
        fill_word  <= fillValue;
        scroll_row <= (scroll_row == ROW_LAST) ? '0 : scroll_row + ROW_WIDTH'(1);
      end else if (state != ST_IDLE) begin
        fill_addr <= fill_addr + ADDR_WIDTH'(1);
        fill_left <= fill_left - ADDR_WIDTH'(1);
      end
    end
  end

  // Logical row to physical row through the scroll offset, one wrap at most.
  always_comb begin
    phys_sum        = {1'b0, renderRow} + {1'b0, scroll_row};
    phys_row        = (phys_sum >= ROWS_EXT) ? phys_sum - ROWS_EXT : phys_sum;
    render_in_range = (32'(renderColumn) < COLUMNS) && (32'(renderRow) < ROWS);
    render_addr     = ADDR_WIDTH'(phys_row) * ADDR_WIDTH'(COLUMNS) + ADDR_WIDTH'(renderColumn);
  end

  assign ram_en_a = s1_valid && s1_in_range;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_addr     <= '0;
      s2_valid    <= 1'b0;
      s2_in_range <= 1'b0;
      renderValid <= 1'b0;
      renderData  <= '0;
    end else begin
      s1_valid    <= renderEnable;
      s1_in_range <= render_in_range;
      s1_addr     <= render_addr;
      s2_valid    <= s1_valid;
      s2_in_range <= s1_in_range;
      renderValid <= s2_valid;
      if (s2_valid) renderData <= s2_in_range ? ram_dout_a : MEM_INIT_VAL;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      cpu_rd_pending <= 1'b0;
      cpuReadValid   <= 1'b0;
      cpuReadData    <= '0;
    end else begin
      cpu_rd_pending <= cpu_accept && !cpuWrite;
      cpuReadValid   <= cpu_rd_pending;
      if (cpu_rd_pending) cpuReadData <= ram_dout_b;
    end
  end

  text_screen_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MEM_INIT_FILE(MEM_INIT_FILE),
    .MEM_INIT_VAL (MEM_INIT_VAL)
  ) u_ram (
    .clk   (clock),
    .en_a  (ram_en_a),
    .addr_a(s1_addr),
    .dout_a(ram_dout_a),
    .en_b  (ram_en_b),
    .we_b  (ram_we_b),
    .addr_b(ram_addr_b),
    .din_b (ram_din_b),
    .dout_b(ram_dout_b)
  );

endmodule

// File: tb/tb_text_screen_buffer.sv
// Bench for text_screen_buffer: directed steps plus random traffic against a cell-array model.
module tb_text_screen_buffer;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;
  localparam int DEPTH = 2048;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        renderEnable = 1'b0;
  logic [6:0]  renderColumn = '0;
  logic [4:0]  renderRow = '0;
  logic [15:0] renderData;
  logic        renderValid;
  logic        cpuRequest = 1'b0;
  logic        cpuReady;
  logic        cpuWrite = 1'b0;
  logic [1:0]  cpuByteEnable = '0;
  logic [10:0] cpuAddress = '0;
  logic [15:0] cpuWriteData = '0;
  logic [15:0] cpuReadData;
  logic        cpuReadValid;
  logic        clearStart = 1'b0;
  logic        scrollStart = 1'b0;
  logic [15:0] fillValue = '0;
  logic        busy;
  logic [4:0]  scrollRow;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mscroll = 0;
  logic [15:0] mdl [DEPTH];
  logic [15:0] burst_q [$];

  text_screen_buffer dut (
    .clock        (clock),
    .resetN       (resetN),
    .renderEnable (renderEnable),
    .renderColumn (renderColumn),
    .renderRow    (renderRow),
    .renderData   (renderData),
    .renderValid  (renderValid),
    .cpuRequest   (cpuRequest),
    .cpuReady     (cpuReady),
    .cpuWrite     (cpuWrite),
    .cpuByteEnable(cpuByteEnable),
    .cpuAddress   (cpuAddress),
    .cpuWriteData (cpuWriteData),
    .cpuReadData  (cpuReadData),
    .cpuReadValid (cpuReadValid),
    .clearStart   (clearStart),
    .scrollStart  (scrollStart),
    .fillValue    (fillValue),
    .busy         (busy),
    .scrollRow    (scrollRow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old_w;
    if (be[0]) r[7:0] = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  function automatic logic [15:0] exp_render(input int col, input int row);
    if (col >= COLS || row >= ROWS) return 16'h0000;
    return mdl[((row + mscroll) % ROWS) * COLS + col];
  endfunction

  task automatic cpu_write(input int addr, input logic [15:0] data, input logic [1:0] be);
    chk("cpu_ready_idle", 32'(cpuReady), 1);
    cpuRequest = 1'b1; cpuWrite = 1'b1; cpuAddress = 11'(addr);
    cpuWriteData = data; cpuByteEnable = be;
    tick();
    cpuRequest = 1'b0; cpuWrite = 1'b0; cpuByteEnable = '0;
    mdl[addr] = merge(mdl[addr], data, be);
  endtask

  task automatic cpu_read(input int addr, input string tag);
    logic [15:0] e;
    e = mdl[addr];
    cpuRequest = 1'b1; cpuWrite = 1'b0; cpuAddress = 11'(addr);
    tick();
    cpuRequest = 1'b0;
    chk({tag, "_valid_early"}, 32'(cpuReadValid), 0);
    tick();
    chk({tag, "_valid"}, 32'(cpuReadValid), 1);
    chk({tag, "_data"}, 32'(cpuReadData), 32'(e));
    tick();
    chk({tag, "_valid_once"}, 32'(cpuReadValid), 0);
  endtask

  task automatic render(input int col, input int row, input string tag);
    logic [15:0] e;
    e = exp_render(col, row);
    renderEnable = 1'b1; renderColumn = 7'(col); renderRow = 5'(row);
    tick();
    renderEnable = 1'b0;
    tick();
    chk({tag, "_valid_early"}, 32'(renderValid), 0);
    tick();
    chk({tag, "_valid"}, 32'(renderValid), 1);
    chk({tag, "_data"}, 32'(renderData), 32'(e));
  endtask

  task automatic command(input bit do_clear, input bit do_scroll, input logic [15:0] fill,
                         input bit mid_check);
    int acc;
    int old;
    bit ready_ok;
    clearStart = do_clear; scrollStart = do_scroll; fillValue = fill;
    tick();
    clearStart = 1'b0; scrollStart = 1'b0; fillValue = 16'($urandom);
    acc = cyc;
    old = mscroll;
    if (!do_clear) mscroll = (mscroll + 1) % ROWS;
    chk("busy_rise", 32'(busy), 1);
    chk("scroll_row_accept", 32'(scrollRow), 32'(mscroll));
    if (mid_check) render(0, 23, "render_mid_scroll");
    ready_ok = 1'b1;
    while (busy && (cyc - acc) < 3000) begin
      if (cpuReady) ready_ok = 1'b0;
      tick();
    end
    chk("ready_low_while_busy", 32'(ready_ok), 1);
    chk(do_clear ? "clear_len" : "scroll_len", 32'(cyc - acc), do_clear ? CELLS : COLS);
    if (do_clear) for (int i = 0; i < CELLS; i++) mdl[i] = fill;
    else for (int c = 0; c < COLS; c++) mdl[old * COLS + c] = fill;
  endtask

  initial begin
    int          a;
    int          acc;
    logic [15:0] e;
    logic [15:0] f;

    for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;

    // Reset state
    tick(3);
    chk("rst_render_valid", 32'(renderValid), 0);
    chk("rst_render_data", 32'(renderData), 0);
    chk("rst_read_valid", 32'(cpuReadValid), 0);
    chk("rst_read_data", 32'(cpuReadData), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_scroll_row", 32'(scrollRow), 0);
    resetN = 1'b1;
    tick();
    render(0, 0, "render_origin");

    // Byte-masked writes merge into one word
    cpu_write(0, 16'h1E41, 2'b01);
    cpu_write(0, 16'hFF00, 2'b10);
    cpu_read(0, "byte_merge");
    chk("byte_merge_word", 32'(mdl[0]), 32'h0000FF41);

    // Full clear
    command(1'b1, 1'b0, 16'h0720, 1'b0);
    cpu_read(1999, "clear_last_cell");

    // Scroll with stale-row read mid-command and cleared row afterwards
    cpu_write(24 * COLS, 16'hAAAA, 2'b11);
    command(1'b0, 1'b1, 16'h0000, 1'b1);
    render(0, 24, "render_exposed_row");

    // 25 scrolls wrap the offset back round
    for (int i = 0; i < 25; i++) command(1'b0, 1'b1, 16'($urandom), 1'b0);
    chk("scroll_wrap", 32'(scrollRow), 1);

    // CPU read, clear and scroll in the same idle cycle
    a = int'($urandom_range(0, DEPTH - 1));
    e = mdl[a];
    f = 16'($urandom);
    cpuRequest = 1'b1; cpuWrite = 1'b0; cpuAddress = 11'(a);
    clearStart = 1'b1; scrollStart = 1'b1; fillValue = f;
    tick();
    cpuRequest = 1'b0; clearStart = 1'b0; scrollStart = 1'b0;
    acc = cyc;
    chk("combo_scroll_unchanged", 32'(scrollRow), 32'(mscroll));
    tick();
    chk("combo_read_valid", 32'(cpuReadValid), 1);
    chk("combo_read_data", 32'(cpuReadData), 32'(e));
    while (busy && (cyc - acc) < 3000) tick();
    chk("combo_clear_len", 32'(cyc - acc), CELLS);
    chk("combo_scroll_after", 32'(scrollRow), 32'(mscroll));
    for (int i = 0; i < CELLS; i++) mdl[i] = f;

    // Random CPU and renderer traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: cpu_write(int'($urandom_range(0, DEPTH - 1)), 16'($urandom), 2'($urandom_range(1, 3)));
        1: cpu_read(int'($urandom_range(0, DEPTH - 1)), "rand_read");
        default: render(int'($urandom_range(0, 85)), int'($urandom_range(0, 27)), "rand_render");
      endcase
    end

    // Back-to-back renderer requests
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        int c;
        int r;
        c = int'($urandom_range(0, 82));
        r = int'($urandom_range(0, 26));
        renderEnable = 1'b1; renderColumn = 7'(c); renderRow = 5'(r);
        burst_q.push_back(exp_render(c, r));
      end else begin
        renderEnable = 1'b0;
      end
      tick();
      if (i >= 2) begin
        chk("burst_valid", 32'(renderValid), 1);
        chk("burst_data", 32'(renderData), 32'(burst_q.pop_front()));
      end
    end

    // Out-of-range renderer column
    render(80, 0, "render_out_of_range");

    // Reset 100 cycles into a clear
    cpu_write(500, 16'h5A5A, 2'b11);
    clearStart = 1'b1; fillValue = 16'h0E2E;
    tick();
    clearStart = 1'b0; fillValue = 16'h0000;
    tick(100);
    resetN = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_scroll_row", 32'(scrollRow), 0);
    resetN = 1'b1;
    mscroll = 0;
    for (int i = 0; i < 100; i++) mdl[i] = 16'h0E2E;
    tick();
    cpu_read(99, "abort_cell_99");
    cpu_read(500, "abort_cell_500");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
